// File: rtl/alu_arbiter_pkg.sv
// Shared ALU opcode encoding and arbiter state
// types for the alu_arbiter slice.
package alu_arbiter_pkg;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_MUL  = 4'b0011,
    ALU_RSV4 = 4'b0100,
    ALU_RSV5 = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_SLL  = 4'b1000,
    ALU_SLTS = 4'b1001,
    ALU_SLTU = 4'b1010,
    ALU_XOR  = 4'b1011,
    ALU_SRL  = 4'b1100,
    ALU_SRA  = 4'b1101,
    ALU_RSVE = 4'b1110,
    ALU_RSVF = 4'b1111
  } alu_op_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 64-bit ALU; reserved opcodes
// produce zero and raise err_o.
module alu
  import alu_arbiter_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [3:0]      ctrl_signal_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  output logic [XLEN-1:0] result_o,
  output logic            err_o
);

  logic [4:0] w_shamt;
  logic       w_lts;
  logic       w_ltu;

  assign w_shamt = op2_i[4:0];
  assign w_lts   = $signed(op1_i) < $signed(op2_i);
  assign w_ltu   = op1_i < op2_i;

  always_comb begin
    result_o = '0;
    err_o    = 1'b0;
    case (ctrl_signal_i)
      ALU_AND:  result_o = op1_i & op2_i;
      ALU_OR:   result_o = op1_i | op2_i;
      ALU_ADD:  result_o = op1_i + op2_i;
      ALU_MUL:  result_o = op1_i * op2_i;
      ALU_SUB:  result_o = op1_i - op2_i;
      ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, w_lts};
      ALU_SLL:  result_o = op1_i << w_shamt;
      ALU_SLTS: result_o = {{(XLEN-1){1'b0}}, w_lts};
      ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, w_ltu};
      ALU_XOR:  result_o = op1_i ^ op2_i;
      ALU_SRL:  result_o = op1_i >> w_shamt;
      ALU_SRA:  result_o = $signed(op1_i) >>> w_shamt;
      default:  err_o    = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sharing
// one ALU, with a one-entry result register.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req0_valid_i,
  output logic            req0_ready_o,
  input  logic [3:0]      req0_ctrl_i,
  input  logic [XLEN-1:0] req0_op1_i,
  input  logic [XLEN-1:0] req0_op2_i,
  input  logic            req1_valid_i,
  output logic            req1_ready_o,
  input  logic [3:0]      req1_ctrl_i,
  input  logic [XLEN-1:0] req1_op1_i,
  input  logic [XLEN-1:0] req1_op2_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic            resp_id_o,
  output logic [XLEN-1:0] resp_result_o,
  output logic            resp_err_o
);

  arb_state_e      r_state;
  logic            r_ptr;
  logic            r_id;
  logic [XLEN-1:0] r_result;
  logic            r_err;

  logic            w_gnt;
  logic            w_slot;
  logic            w_acc;
  logic [3:0]      w_ctrl;
  logic [XLEN-1:0] w_op1;
  logic [XLEN-1:0] w_op2;
  logic [XLEN-1:0] w_res;
  logic            w_err;

  // Pointer only matters on a tie; a lone valid wins.
  assign w_gnt = (req0_valid_i & req1_valid_i)
               ? r_ptr : req1_valid_i;

  assign w_slot = ~rst_i &
    ((r_state == ST_EMPTY) | resp_ready_i);

  assign req0_ready_o = w_slot & req0_valid_i & ~w_gnt;
  assign req1_ready_o = w_slot & req1_valid_i & w_gnt;

  assign w_acc = (req0_valid_i & req0_ready_o) |
                 (req1_valid_i & req1_ready_o);

  assign w_ctrl = w_gnt ? req1_ctrl_i : req0_ctrl_i;
  assign w_op1  = w_gnt ? req1_op1_i  : req0_op1_i;
  assign w_op2  = w_gnt ? req1_op2_i  : req0_op2_i;

  alu #(.XLEN(XLEN)) u_alu (
    .ctrl_signal_i (w_ctrl),
    .op1_i         (w_op1),
    .op2_i         (w_op2),
    .result_o      (w_res),
    .err_o         (w_err)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_EMPTY;
      r_ptr    <= 1'b0;
      r_id     <= 1'b0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else if (w_acc) begin
      r_state  <= ST_FULL;
      r_ptr    <= ~w_gnt;
      r_id     <= w_gnt;
      r_result <= w_res;
      r_err    <= w_err;
    end else if (resp_ready_i) begin
      r_state  <= ST_EMPTY;
    end
  end

  assign resp_valid_o  = (r_state == ST_FULL);
  assign resp_id_o     = r_id;
  assign resp_result_o = r_result;
  assign resp_err_o    = r_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a
// transaction-level reference model.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        v0, v1, rdy0, rdy1;
  logic [3:0]  c0, c1;
  logic [63:0] a0, b0, a1, b1;
  logic        rvalid, rready, rid, rerr;
  logic [63:0] rres;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  // model state
  bit          m_valid, m_ptr, m_id, m_err;
  logic [63:0] m_res;

  always #5 clk = ~clk;

  alu_arbiter #(.XLEN(64)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req0_valid_i  (v0),
    .req0_ready_o  (rdy0),
    .req0_ctrl_i   (c0),
    .req0_op1_i    (a0),
    .req0_op2_i    (b0),
    .req1_valid_i  (v1),
    .req1_ready_o  (rdy1),
    .req1_ctrl_i   (c1),
    .req1_op1_i    (a1),
    .req1_op2_i    (b1),
    .resp_valid_o  (rvalid),
    .resp_ready_i  (rready),
    .resp_id_o     (rid),
    .resp_result_o (rres),
    .resp_err_o    (rerr)
  );

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  function automatic bit is_rsv(logic [3:0] op);
    return op == 4 || op == 5 || op == 14 || op == 15;
  endfunction

  function automatic logic [63:0] ref_alu(
    logic [3:0] op, logic [63:0] x, logic [63:0] y);
    longint sx = x;
    longint sy = y;
    int     sh = int'(y % 32);
    case (op)
      0:  return x & y;
      1:  return x | y;
      2:  return x + y;
      3:  return x * y;
      6:  return x - y;
      7, 9: return (sx < sy) ? 64'd1 : 64'd0;
      8:  return x << sh;
      10: return (x < y) ? 64'd1 : 64'd0;
      11: return x ^ y;
      12: return x >> sh;
      13: return 64'(sx >>> sh);
      default: return 64'd0;
    endcase
  endfunction

  // Compare process: inputs are stable from
  // posedge+1 through the next posedge.
  always @(negedge clk) begin
    bit slot, e0, e1, g;
    if (mon_en) begin
      chk("resp_valid", 64'(rvalid), 64'(m_valid));
      chk("resp_id", 64'(rid), 64'(m_id));
      chk("resp_result", rres, m_res);
      chk("resp_err", 64'(rerr), 64'(m_err));
      slot = !rst && (!m_valid || rready);
      e0 = slot && v0 && (!v1 || m_ptr == 1'b0);
      e1 = slot && v1 && (!v0 || m_ptr == 1'b1);
      chk("req0_ready", 64'(rdy0), 64'(e0));
      chk("req1_ready", 64'(rdy1), 64'(e1));
    end
    if (rst) begin
      m_valid = 0; m_ptr = 0; m_id = 0;
      m_err = 0; m_res = '0;
    end else if (e0 || e1) begin
      g = e1;
      m_valid = 1;
      m_id    = g;
      m_ptr   = !g;
      m_res   = g ? ref_alu(c1, a1, b1)
                  : ref_alu(c0, a0, b0);
      m_err   = g ? is_rsv(c1) : is_rsv(c0);
    end else if (rready) begin
      m_valid = 0;
    end
  end

  task automatic cyc(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drv0(bit v, logic [3:0] c,
                      logic [63:0] x, logic [63:0] y);
    v0 = v; c0 = c; a0 = x; b0 = y;
  endtask

  task automatic drv1(bit v, logic [3:0] c,
                      logic [63:0] x, logic [63:0] y);
    v1 = v; c1 = c; a1 = x; b1 = y;
  endtask

  initial begin
    rst = 1'b1; rready = 1'b0;
    drv0(0, 0, 0, 0);
    drv1(0, 0, 0, 0);
    cyc(2);
    mon_en = 1'b1;
    chk("rst_valid", 64'(rvalid), 64'd0);
    chk("rst_result", rres, 64'd0);
    chk("rst_rdy0", 64'(rdy0), 64'd0);

    // single ADD from req0
    rst = 1'b0; rready = 1'b1;
    drv0(1, 4'b0010, 64'd5, 64'd7);
    cyc();
    drv0(0, 0, 0, 0);
    chk("add_valid", 64'(rvalid), 64'd1);
    chk("add_id", 64'(rid), 64'd0);
    chk("add_res", rres, 64'd12);
    chk("add_err", 64'(rerr), 64'd0);
    cyc();

    // alternating grants from reset
    rst = 1'b1; cyc(); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drv0(1, 4'b0010, 64'(i), 64'd100);
      drv1(1, 4'b1011, 64'(i), 64'hFF);
      #1;
      chk("rr_rdy0", 64'(rdy0), 64'(i % 2 == 0));
      chk("rr_rdy1", 64'(rdy1), 64'(i % 2 == 1));
      cyc();
    end
    drv0(0, 0, 0, 0);
    drv1(0, 0, 0, 0);
    cyc();

    // stall with req1 SUB pending
    rst = 1'b1; cyc(); rst = 1'b0;
    rready = 1'b0;
    drv0(1, 4'b0010, 64'd3, 64'd5);
    cyc();
    drv0(0, 0, 0, 0);
    drv1(1, 4'b0110, 64'd10, 64'd3);
    for (int i = 0; i < 3; i++) begin
      chk("stall_rdy1", 64'(rdy1), 64'd0);
      chk("stall_res", rres, 64'd8);
      chk("stall_id", 64'(rid), 64'd0);
      cyc();
    end
    rready = 1'b1; #1;
    chk("drain_rdy1", 64'(rdy1), 64'd1);
    cyc();
    drv1(0, 0, 0, 0);
    chk("sub_res", rres, 64'd7);
    chk("sub_id", 64'(rid), 64'd1);

    // reserved opcode then a clean ADD
    drv0(1, 4'b1110, 64'd9, 64'd9);
    cyc();
    chk("rsv_err", 64'(rerr), 64'd1);
    chk("rsv_res", rres, 64'd0);
    drv0(1, 4'b0010, 64'd2, 64'd2);
    cyc();
    chk("post_err", 64'(rerr), 64'd0);
    chk("post_res", rres, 64'd4);

    // shifts and misc ops
    drv0(1, 4'b1101, 64'hFFFF_FFFF_FFFF_FF00, 64'd4);
    cyc();
    chk("sra_res", rres, 64'hFFFF_FFFF_FFFF_FFF0);
    drv0(1, 4'b1000, 64'd3, 64'h21);
    cyc();
    chk("sll_res", rres, 64'd6);
    drv0(1, 4'b0011, 64'd6, 64'd7);
    cyc();
    chk("mul_res", rres, 64'd42);
    drv0(1, 4'b1010, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    cyc();
    chk("sltu_res", rres, 64'd1);
    drv0(1, 4'b0111, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    cyc();
    chk("slt_res", rres, 64'd0);
    drv0(0, 0, 0, 0);
    cyc(2);

    // reset while holding a result
    rready = 1'b0;
    drv0(1, 4'b0001, 64'hF0, 64'h0F);
    cyc();
    chk("pre_rst_valid", 64'(rvalid), 64'd1);
    drv0(0, 0, 0, 0);
    rst = 1'b1;
    cyc();
    chk("rst_full_valid", 64'(rvalid), 64'd0);
    rst = 1'b0; rready = 1'b1;
    drv0(1, 4'b0010, 64'd1, 64'd1);
    drv1(1, 4'b0010, 64'd2, 64'd2);
    #1;
    chk("first_rdy0", 64'(rdy0), 64'd1);
    chk("first_rdy1", 64'(rdy1), 64'd0);
    cyc(3);
    drv0(0, 0, 0, 0);
    drv1(0, 0, 0, 0);
    cyc(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter XLEN, default 64, operand/result width; only 64 is supported by the shared alu instance.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset; synchronous, active-high.
REQ-004 req0_valid_i / req1_valid_i  input  1  requester n presents an operation.
REQ-005 req0_ready_o / req1_ready_o  output  1  operation of requester n accepted this cycle when valid and ready are both high.
REQ-006 req0_ctrl_i / req1_ctrl_i  input  4  ALU opcode, same encoding as alu ctrl_signal_i.
REQ-007 req0_op1_i, req0_op2_i, req1_op1_i, req1_op2_i  input  XLEN  operands.
REQ-008 resp_valid_o  output  1  result slot holds a completed operation.
REQ-009 resp_ready_i  input  1  consumer takes the result when valid and ready are both high.
REQ-010 resp_id_o  output  1  index of the requester that issued the held result.
REQ-011 resp_result_o  output  XLEN  held ALU result.
REQ-012 resp_err_o  output  1  held operation used a reserved opcode (4'b0100, 4'b0101, 4'b1110, 4'b1111).

Function
REQ-013 The block shall time-share one combinational alu instance between two requesters, issuing at most one operation per cycle.
REQ-014 Operands and opcode shall be muxed from the granted requester into the alu, and the output captured into a one-entry result register on acceptance; latency from acceptance to resp_valid_o is exactly 1 cycle.
REQ-015 FSM states: EMPTY (no held result) and FULL (result held).
- EMPTY -> FULL on any acceptance.
- FULL -> EMPTY on resp_ready_i with no acceptance.
- FULL -> FULL on resp_ready_i with a same-cycle acceptance (drain-and-refill), or on stalled resp_ready_i.
REQ-016 An issue slot exists when state is EMPTY, or when state is FULL and resp_ready_i is 1; sustained throughput is one operation per cycle.
REQ-017 Arbitration shall be round-robin over a 1-bit priority pointer: with one valid requester it is granted; with both valid, the pointer side is granted.
REQ-018 After each acceptance, the pointer shall move to the non-granted requester; it shall not change without an acceptance.
REQ-019 reqN_ready_o shall be 1 only for the granted requester when an issue slot exists; it shall be 0 for the loser and whenever no slot exists. It shall depend on the valid inputs only through arbitration.
REQ-020 While FULL and resp_ready_i is 0, resp_valid_o, resp_id_o, resp_result_o and resp_err_o shall remain stable.
REQ-021 A reserved opcode shall still be accepted, returning resp_result_o = 0 and resp_err_o = 1; otherwise resp_err_o = 0.
REQ-022 Shift opcodes use op2[4:0] as the amount; the arbiter passes operands unmodified and performs no width conversion.
REQ-023 A requester holding valid with no acceptance shall not lose its operation; the arbiter never drops or duplicates an accepted operation.

Reset
REQ-024 While rst_i is high, at the next edge: state = EMPTY, pointer = requester 0, resp_valid_o = 0, resp_id_o = 0, resp_result_o = 0, resp_err_o = 0.
REQ-025 During reset, both ready outputs shall be 0.
REQ-026 A result held when reset asserts shall be discarded, with no response emitted.

Structure
REQ-027 A shared package shall hold the 4-bit ALU opcode enum (AND, OR, ADD, MUL, SUB, SLT, SLL, SLTS, SLTU, XOR, SRL, SRA, plus the four reserved codes) and the FSM state typedef; both alu and alu_arbiter import it.
REQ-028 The only sub-module shall be one instance of the existing alu; arbitration, FSM and result register live in alu_arbiter.

Verification
REQ-029 Req0 only: ADD, op1 = 5, op2 = 7, resp_ready_i = 1 -> next cycle resp_valid_o = 1, id = 0, result = 12, err = 0.
REQ-030 Both valid every cycle, resp_ready_i = 1 -> grants alternate 0, 1, 0, 1 from reset; each accepted once per two cycles.
REQ-031 FULL with resp_ready_i = 0 for 3 cycles, req1 SUB 10-3 pending -> outputs frozen and ready low; on resp_ready_i = 1, same-cycle accept, next result = 7, id = 1.
REQ-032 Req0 opcode 4'b1110 -> resp_err_o = 1, resp_result_o = 0; the next ADD returns err = 0.
REQ-033 Reset asserted while FULL -> next cycle resp_valid_o = 0 and pointer = 0; with both valid afterwards, the first grant is req0.
REQ-034 SRA op1 = 64'hFFFF_FFFF_FFFF_FF00, op2 = 4 -> result 64'hFFFF_FFFF_FFFF_FFF0.
